// File: rtl/fp32_vec_stream.sv
// Feeds a packed N-lane fp32 vector to the accumulator one lane per beat, then
// pads with DRAIN +0.0 beats and pulses done once the last beat is taken.
module fp32_vec_stream #(
  parameter int N     = 8,
  parameter int DRAIN = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [32*N-1:0] load_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_data,
  output logic            out_last,
  output logic            out_drain,
  output logic            done,
  output logic            busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [IW-1:0] LANE_LAST  = IW'(N - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'((DRAIN > 0) ? DRAIN - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   idx_reg, idx_next;
  logic [DW-1:0]   drain_cnt_reg, drain_cnt_next;
  logic [31:0]     buf_reg [N];
  logic            capture;

  // Buffer is written only on the IDLE accept, so a stream is never disturbed.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      always_ff @(posedge clk) begin
        if (rst) begin
          buf_reg[gi] <= 32'h0000_0000;
        end else if (capture) begin
          buf_reg[gi] <= load_data[32*gi +: 32];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      idx_reg       <= '0;
      drain_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      drain_cnt_reg <= drain_cnt_next;
    end
  end

  // Outputs decode state only; out_ready steers the next state, never the data.
  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    drain_cnt_next = drain_cnt_reg;
    capture        = 1'b0;
    load_ready     = 1'b0;
    out_valid      = 1'b0;
    out_data       = 32'h0000_0000;
    out_last       = 1'b0;
    out_drain      = 1'b0;
    done           = 1'b0;
    busy           = 1'b1;
    case (state_reg)
      S_IDLE: begin
        load_ready = 1'b1;
        busy       = 1'b0;
        if (load_valid) begin
          capture    = 1'b1;
          idx_next   = '0;
          state_next = S_STREAM;
        end
      end
      S_STREAM: begin
        out_valid = 1'b1;
        out_data  = buf_reg[idx_reg];
        out_last  = (idx_reg == LANE_LAST);
        if (out_ready) begin
          if (idx_reg == LANE_LAST) begin
            drain_cnt_next = '0;
            state_next     = (DRAIN == 0) ? S_DONE : S_DRAIN;
          end else begin
            idx_next = idx_reg + IW'(1);
          end
        end
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        out_drain = 1'b1;
        if (out_ready) begin
          if (drain_cnt_reg == DRAIN_LAST) begin
            state_next = S_DONE;
          end else begin
            drain_cnt_next = drain_cnt_reg + DW'(1);
          end
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fp32_vec_stream.sv
// Directed bench for fp32_vec_stream: N=4/DRAIN=2 instance for streaming, stall,
// ignore-load, reset and back-to-back cases; N=1/DRAIN=0 instance for the corner.
module tb_fp32_vec_stream;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid, load_ready, out_valid, out_ready;
  logic [127:0] load_data;
  logic [31:0]  out_data;
  logic         out_last, out_drain, done, busy;

  logic         load1_valid, load1_ready, out1_valid, out1_ready;
  logic [31:0]  load1_data, out1_data;
  logic         out1_last, out1_drain, done1, busy1;

  int checks = 0;
  int passes = 0;

  logic [127:0] vec_a = {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
  logic [127:0] vec_b = {32'hC080_0000, 32'h7F80_0000, 32'h0000_0001, 32'h8000_0000};

  fp32_vec_stream #(.N(4), .DRAIN(2)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .out_drain(out_drain),
    .done(done), .busy(busy)
  );

  fp32_vec_stream #(.N(1), .DRAIN(0)) dut1 (
    .clk(clk), .rst(rst), .load_valid(load1_valid), .load_ready(load1_ready),
    .load_data(load1_data), .out_valid(out1_valid), .out_ready(out1_ready),
    .out_data(out1_data), .out_last(out1_last), .out_drain(out1_drain),
    .done(done1), .busy(busy1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] lane(input logic [127:0] v, input int k);
    return v[32*k +: 32];
  endfunction

  task automatic beat(input string tag, input logic [31:0] d, input logic last, input logic drn);
    chk({tag, " valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, " data"}, out_data, d);
    chk({tag, " last"}, {31'b0, out_last}, {31'b0, last});
    chk({tag, " drain"}, {31'b0, out_drain}, {31'b0, drn});
    chk({tag, " done"}, {31'b0, done}, 32'd0);
  endtask

  task automatic finish_vec(input string tag, input logic [127:0] v, input int from);
    for (int k = from; k < 4; k++) begin
      beat($sformatf("%s lane%0d", tag, k), lane(v, k), k == 3, 1'b0);
      step();
    end
    for (int k = 0; k < 2; k++) begin
      beat($sformatf("%s drain%0d", tag, k), 32'h0, 1'b0, 1'b1);
      step();
    end
    chk({tag, " done"}, {31'b0, done}, 32'd1);
    chk({tag, " done out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, " done busy"}, {31'b0, busy}, 32'd1);
    chk({tag, " done load_ready"}, {31'b0, load_ready}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; load_valid = 1'b0; load_data = '0; out_ready = 1'b1;
    load1_valid = 1'b0; load1_data = '0; out1_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("reset load_ready", {31'b0, load_ready}, 32'd1);
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset out_data", out_data, 32'h0);
    step();

    // basic stream with out_ready held high
    load_data = vec_a; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    finish_vec("t1", vec_a, 0);
    step();
    chk("t1 idle load_ready", {31'b0, load_ready}, 32'd1);
    chk("t1 idle done", {31'b0, done}, 32'd0);
    chk("t1 idle busy", {31'b0, busy}, 32'd0);

    // backpressure for two cycles on lane 1
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    beat("t2 lane0", lane(vec_a, 0), 1'b0, 1'b0);
    step();
    out_ready = 1'b0;
    beat("t2 lane1 a", lane(vec_a, 1), 1'b0, 1'b0);
    step();
    beat("t2 lane1 b", lane(vec_a, 1), 1'b0, 1'b0);
    step();
    out_ready = 1'b1;
    beat("t2 lane1 c", lane(vec_a, 1), 1'b0, 1'b0);
    step();
    finish_vec("t2", vec_a, 2);
    step();

    // a load offered mid-stream is ignored
    load_data = vec_a; load_valid = 1'b1;
    step();
    load_data = vec_b;
    chk("t3 load_ready", {31'b0, load_ready}, 32'd0);
    finish_vec("t3", vec_a, 0);
    load_valid = 1'b0;
    step();
    chk("t3 idle busy", {31'b0, busy}, 32'd0);

    // reset during lane 2 abandons the vector
    load_data = vec_b; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    step(); step();
    beat("t4 lane2", lane(vec_b, 2), 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t4 out_valid", {31'b0, out_valid}, 32'd0);
    chk("t4 busy", {31'b0, busy}, 32'd0);
    chk("t4 load_ready", {31'b0, load_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("t4 no done", {31'b0, done}, 32'd0);
      step();
    end
    load_data = vec_a; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    finish_vec("t4 reload", vec_a, 0);
    step();

    // N=1, DRAIN=0 with a quiet NaN lane
    load1_data = 32'h7FC0_0000; load1_valid = 1'b1;
    step();
    load1_valid = 1'b0;
    chk("t5 valid", {31'b0, out1_valid}, 32'd1);
    chk("t5 data", out1_data, 32'h7FC0_0000);
    chk("t5 last", {31'b0, out1_last}, 32'd1);
    chk("t5 drain", {31'b0, out1_drain}, 32'd0);
    step();
    chk("t5 done", {31'b0, done1}, 32'd1);
    chk("t5 done out_valid", {31'b0, out1_valid}, 32'd0);
    step();
    chk("t5 load_ready", {31'b0, load1_ready}, 32'd1);
    chk("t5 done cleared", {31'b0, done1}, 32'd0);

    // back-to-back loads with load_valid held high
    load_data = vec_a; load_valid = 1'b1;
    step();
    load_data = vec_b;
    finish_vec("t6 first", vec_a, 0);
    step();
    chk("t6 accept load_ready", {31'b0, load_ready}, 32'd1);
    chk("t6 accept busy", {31'b0, busy}, 32'd0);
    step();
    load_valid = 1'b0;
    chk("t6 second busy", {31'b0, busy}, 32'd1);
    finish_vec("t6 second", vec_b, 0);
    step();
    chk("t6 end busy", {31'b0, busy}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
